platform_switch_poller: RTL and testbench



---
 rtl/platform_pio_pkg.sv | 14 +
 rtl/platform_debounce.sv | 63 ++++++
 rtl/platform_switch_poller.sv | 109 ++++++++++
 tb/tb_platform_switch_poller.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pio_pkg.sv
// Shared definitions for the switch PIO poller: master FSM states and
// PIO register map constants.
package platform_pio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_t;

  localparam logic [1:0] DATA_ADDR = 2'd0;
  localparam int         RDATA_W   = 32;

endpackage

// File: rtl/platform_debounce.sv
// Debounces sampled switch bits and publishes accepted changes as a
// valid/ready event whose mask accumulates while the event is pending.
module platform_debounce
  import platform_pio_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic [WIDTH-1:0] switch_state,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_mask,
  input  logic             change_ready
);

  localparam int             CW        = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(STABLE_SAMPLES);

  logic [WIDTH-1:0] candidate_reg;
  logic [CW-1:0]    count_reg;
  logic             accept;
  logic             handshake;
  logic [WIDTH-1:0] diff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate_reg <= '0;
      count_reg     <= '0;
    end else if (sample_valid) begin
      if (sample_data == candidate_reg) begin
        if (count_reg != COUNT_MAX) count_reg <= count_reg + CW'(1);
      end else begin
        candidate_reg <= sample_data;
        count_reg     <= CW'(1);
      end
    end
  end

  // Once accepted, switch_state equals candidate, so this fires only once
  // per stable run, in the cycle right after the deciding sample.
  assign accept    = (count_reg == COUNT_MAX) && (candidate_reg != switch_state);
  assign handshake = change_valid & change_ready;
  assign diff      = candidate_reg ^ switch_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      switch_state <= '0;
      change_valid <= 1'b0;
      change_mask  <= '0;
    end else if (accept) begin
      switch_state <= candidate_reg;
      change_valid <= 1'b1;
      change_mask  <= (change_valid && !handshake) ? (change_mask | diff) : diff;
    end else if (handshake) begin
      change_valid <= 1'b0;
      change_mask  <= '0;
    end
  end

endmodule

// File: rtl/platform_switch_poller.sv
// Avalon-MM read master that polls the switch PIO data register at a fixed
// interval and feeds each sample to the debouncer.
module platform_switch_poller
  import platform_pio_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int POLL_CYCLES    = 1000,
  parameter int STABLE_SAMPLES = 3,
  parameter int READ_LATENCY   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic [1:0]         avm_address,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [RDATA_W-1:0] avm_readdata,
  output logic [WIDTH-1:0]   switch_state,
  output logic               change_valid,
  output logic [WIDTH-1:0]   change_mask,
  input  logic               change_ready
);

  localparam int            PW          = $clog2(POLL_CYCLES);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);
  localparam int            LW          = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST    = LW'(READ_LATENCY - 1);

  poll_state_t   state_reg, state_next;
  logic [PW-1:0] poll_cnt_reg, poll_cnt_next;
  logic [LW-1:0] lat_cnt_reg, lat_cnt_next;
  logic          read;
  logic          sample_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      poll_cnt_reg <= POLL_RELOAD;
      lat_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      poll_cnt_reg <= poll_cnt_next;
      lat_cnt_reg  <= lat_cnt_next;
    end
  end

  // enable only gates the idle countdown; a started read always finishes.
  always_comb begin
    state_next    = state_reg;
    poll_cnt_next = poll_cnt_reg;
    lat_cnt_next  = lat_cnt_reg;
    read          = 1'b0;
    sample_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!enable) begin
          poll_cnt_next = POLL_RELOAD;
        end else if (poll_cnt_reg == '0) begin
          state_next    = REQ;
          poll_cnt_next = POLL_RELOAD;
        end else begin
          poll_cnt_next = poll_cnt_reg - PW'(1);
        end
      end
      REQ: begin
        read = 1'b1;
        if (!avm_waitrequest) begin
          state_next   = WAIT;
          lat_cnt_next = '0;
        end
      end
      WAIT: begin
        if (lat_cnt_reg == LAT_LAST) begin
          sample_valid = 1'b1;
          state_next   = IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg + LW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Driven straight from the state register so reset drops it asynchronously.
  assign avm_read    = read;
  assign avm_address = DATA_ADDR;

  generate
    if (WIDTH < RDATA_W) begin : g_upper
      logic unused_upper_bits;
      assign unused_upper_bits = ^avm_readdata[RDATA_W-1:WIDTH];
    end
  endgenerate

  platform_debounce #(
    .WIDTH          (WIDTH),
    .STABLE_SAMPLES (STABLE_SAMPLES)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (avm_readdata[WIDTH-1:0]),
    .switch_state (switch_state),
    .change_valid (change_valid),
    .change_mask  (change_mask),
    .change_ready (change_ready)
  );

endmodule

// File: tb/tb_platform_switch_poller.sv
// Self-checking bench: Avalon slave responder, per-cycle reference model of
// the debounce/event behaviour, a vector table and a few directed sequences.
module tb_platform_switch_poller;

  localparam int W      = 2;
  localparam int POLL   = 8;
  localparam int STABLE = 3;
  localparam int LAT    = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [W-1:0] switch_state;
  logic        change_valid;
  logic [W-1:0] change_mask;
  logic        change_ready;

  always #5 clk = ~clk;

  platform_switch_poller #(
    .WIDTH          (W),
    .POLL_CYCLES    (POLL),
    .STABLE_SAMPLES (STABLE),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .switch_state    (switch_state),
    .change_valid    (change_valid),
    .change_mask     (change_mask),
    .change_ready    (change_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus-owned controls read by the slave/model process.
  logic [31:0] next_data;
  int          wr_hold_cfg;
  bit          rand_wr;

  // Slave/model-owned state.
  int          sample_cnt = 0;
  int          reads_issued = 0;
  int          last_read_len = 0;
  int          phase = 0;
  int          k = 0;
  int          idle_run = 0;
  int          read_len = 0;
  int          wr_cnt = 0;
  int          wr_left = 0;
  logic [W-1:0] drv_val = '0;
  logic [W-1:0] hist[$];
  bit          pending = 0;
  logic [W-1:0] m_state = '0;
  logic [W-1:0] m_mask = '0;
  logic        m_valid = 1'b0;
  logic [W-1:0] m_diff;
  bit          m_hs, m_acc, m_eq;

  // Slave responder plus reference model: a change is accepted when the last
  // STABLE samples all agree and differ from the reported state.
  initial begin : slave_model
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_state = '0; m_mask = '0; m_valid = 1'b0;
        hist.delete(); pending = 0;
        phase = 0; idle_run = 0; wr_left = 0;
      end else begin
        m_hs  = m_valid && change_ready;
        m_acc = 0;
        if (pending && hist.size() == STABLE) begin
          m_eq = 1;
          foreach (hist[i]) if (hist[i] != hist[STABLE-1]) m_eq = 0;
          m_acc = m_eq && (hist[STABLE-1] != m_state);
        end
        if (m_acc) begin
          m_diff  = hist[STABLE-1] ^ m_state;
          m_mask  = (m_valid && !m_hs) ? (m_mask | m_diff) : m_diff;
          m_state = hist[STABLE-1];
          m_valid = 1'b1;
        end else if (m_hs) begin
          m_valid = 1'b0;
          m_mask  = '0;
        end
        pending = 0;
        case (phase)
          0: idle_run = enable ? idle_run + 1 : 0;
          1: if (!avm_waitrequest) begin
               check("read_hold_len", read_len, wr_cnt + 1);
               last_read_len = read_len;
               phase = 2;
               k = 0;
             end
          2: if (k == LAT) begin
               hist.push_back(drv_val);
               if (hist.size() > STABLE) void'(hist.pop_front());
               pending = 1;
               sample_cnt++;
               phase = 0;
             end
          default: phase = 0;
        endcase
      end
      @(negedge clk);
      if (reset_n) begin
        check("switch_state", switch_state, m_state);
        check("change_valid", change_valid, m_valid);
        check("change_mask", change_mask, m_mask);
        if (avm_read) check("avm_address", avm_address, 0);
        case (phase)
          0: begin
               check("read_issue", avm_read, idle_run == POLL);
               if (avm_read) begin
                 idle_run = 0; phase = 1; read_len = 0; wr_cnt = 0;
                 wr_left = wr_hold_cfg; reads_issued++;
               end
             end
          1: check("read_held", avm_read, 1);
          2: check("read_dropped", avm_read, 0);
          default: ;
        endcase
        if (phase == 1) begin
          read_len++;
          if (wr_left > 0) begin
            avm_waitrequest = 1'b1;
            wr_left--;
          end else begin
            avm_waitrequest = rand_wr ? ($urandom_range(0, 2) == 0) : 1'b0;
          end
          if (avm_waitrequest) wr_cnt++;
        end else begin
          avm_waitrequest = 1'($urandom_range(0, 1));
        end
        if (phase == 2) k++;
        if (phase == 2 && k == LAT) begin
          avm_readdata = next_data;
          drv_val      = next_data[W-1:0];
        end else begin
          avm_readdata = $urandom;
        end
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
      end
    end
  end

  // Runs one poll with the given read data; hs_acc pulses ready in exactly
  // the cycle the resulting accept happens.
  task automatic do_poll(input logic [31:0] d, input bit rnd, input bit hs_acc);
    int start;
    start = sample_cnt;
    next_data = d;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sample_cnt != start) break;
      if (rnd) begin
        change_ready = 1'($urandom_range(0, 1));
        enable       = ($urandom_range(0, 19) != 0);
      end
    end
    check("poll_completed", sample_cnt != start, 1);
    if (hs_acc) change_ready = 1'b1;
    @(negedge clk);
    if (hs_acc) change_ready = 1'b0;
    $display("poll %0d: data=%h state=%b valid=%b mask=%b", sample_cnt, d,
             switch_state, change_valid, change_mask);
  endtask

  typedef struct {
    logic [31:0]  data;
    logic         ready;
    logic [W-1:0] st;
    logic         vld;
    logic [W-1:0] msk;
  } vec_t;

  vec_t vecs[18];

  initial begin : stimulus
    int s0, r0;
    logic [31:0] cur;
    vecs[0]  = '{32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[1]  = '{32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[2]  = '{32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[3]  = '{32'h0000_0002, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[4]  = '{32'h0000_0002, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[5]  = '{32'h0000_0002, 1'b0, 2'b10, 1'b1, 2'b10};
    vecs[6]  = '{32'h0000_0002, 1'b1, 2'b10, 1'b0, 2'b00};
    vecs[7]  = '{32'h0000_0000, 1'b0, 2'b10, 1'b0, 2'b00};
    vecs[8]  = '{32'h0000_0000, 1'b0, 2'b10, 1'b0, 2'b00};
    vecs[9]  = '{32'h0000_0000, 1'b0, 2'b00, 1'b1, 2'b10};
    vecs[10] = '{32'h0000_0001, 1'b1, 2'b00, 1'b0, 2'b00};
    vecs[11] = '{32'h0000_0000, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[12] = '{32'h0000_0001, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[13] = '{32'h0000_0001, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[14] = '{32'h0000_0001, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[15] = '{32'h0000_0003, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[16] = '{32'h0000_0003, 1'b0, 2'b01, 1'b1, 2'b01};
    vecs[17] = '{32'h0000_0003, 1'b0, 2'b11, 1'b1, 2'b11};

    reset_n = 1'b0; enable = 1'b0; change_ready = 1'b0;
    next_data = '0; wr_hold_cfg = 0; rand_wr = 0;
    repeat (3) @(negedge clk);
    check("rst_avm_read", avm_read, 0);
    check("rst_switch_state", switch_state, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_change_mask", change_mask, 0);
    reset_n = 1'b1;
    enable  = 1'b1;

    foreach (vecs[i]) begin
      change_ready = vecs[i].ready;
      do_poll(vecs[i].data, 0, 0);
      check($sformatf("vec%0d_state", i), switch_state, vecs[i].st);
      check($sformatf("vec%0d_valid", i), change_valid, vecs[i].vld);
      check($sformatf("vec%0d_mask", i), change_mask, vecs[i].msk);
    end
    change_ready = 1'b0;

    // Ready coinciding with a new accept: mask restarts from the new diff.
    do_poll(32'h1, 0, 0);
    do_poll(32'h1, 0, 0);
    check("pend_mask", change_mask, 2'b11);
    do_poll(32'h1, 0, 1);
    check("hs_acc_state", switch_state, 2'b01);
    check("hs_acc_valid", change_valid, 1);
    check("hs_acc_mask", change_mask, 2'b10);
    @(negedge clk);
    change_ready = 1'b1;
    @(negedge clk);
    change_ready = 1'b0;
    check("ready_clr_valid", change_valid, 0);
    check("ready_clr_mask", change_mask, 0);

    // Stalled read: held for the stall plus one cycle, a single sample.
    wr_hold_cfg = 5;
    s0 = sample_cnt;
    r0 = reads_issued;
    do_poll(32'h1, 0, 0);
    wr_hold_cfg = 0;
    check("stall_read_len", last_read_len, 6);
    repeat (3) @(negedge clk);
    check("stall_samples", sample_cnt - s0, 1);
    check("stall_reads", reads_issued - r0, 1);

    // Randomized polling against the model.
    rand_wr = 1;
    cur = 32'h1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) cur = $urandom;
      do_poll(cur, 1, 0);
    end
    rand_wr = 0;
    change_ready = 1'b0;

    // Disabled: no further reads once any in-flight read has finished.
    enable = 1'b0;
    repeat (15) @(negedge clk);
    r0 = reads_issued;
    repeat (40) @(negedge clk);
    check("disabled_reads", reads_issued, r0);
    check("disabled_read_low", avm_read, 0);

    // Reset asserted while a read is stalled.
    enable = 1'b1;
    change_ready = 1'b1;
    repeat (2) @(negedge clk);
    change_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_poll(32'h3, 0, 0);
    check("pre_rst_state", switch_state, 2'b11);
    wr_hold_cfg = 50;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (avm_read) break;
    end
    check("mid_read_seen", avm_read, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_avm_read", avm_read, 0);
    check("async_switch_state", switch_state, 0);
    check("async_change_valid", change_valid, 0);
    check("async_change_mask", change_mask, 0);
    wr_hold_cfg = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    do_poll(32'h0, 0, 0);
    check("post_rst_state", switch_state, 0);
    check("post_rst_valid", change_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
